echo_detector: RTL and testbench

- Receive-side counterpart of the H-bridge ping transmitter.
- After a ping, it blanks the transducer ring-down, then watches rectified 10-bit ADC samples for the returning echo.
- It reports time-of-flight in clock cycles and the peak magnitude, or a timeout if no echo arrives.
- It sits in dvl_top between the ADC input and the (future) I2C register interface; `rx_en` feeds the txrx select.

---
 rtl/dvl_params.sv | 19 +
 rtl/adc_magnitude.sv | 24 ++
 rtl/echo_detector.sv | 128 ++++++++++++
 tb/tb_echo_detector.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvl_params.sv
// Shared constants and state type for the DVL receive path.
package dvl_params;

   localparam int unsigned DEF_ADC_W         = 10;
   localparam int unsigned DEF_CNT_W         = 16;
   localparam int unsigned DEF_BLANK_CYCLES  = 8;
   localparam int unsigned DEF_WINDOW_CYCLES = 64;
   localparam int unsigned DEF_HOLD          = 3;
   localparam int unsigned ADC_MIDSCALE      = 2 ** (DEF_ADC_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      BLANK,
      LISTEN,
      DONE_ECHO,
      DONE_TO
   } rx_state_t;

endpackage

// File: rtl/adc_magnitude.sv
// Offset-binary ADC sample to absolute distance from midscale (combinational).
module adc_magnitude
   import dvl_params::*;
#(
   parameter int unsigned ADC_W    = DEF_ADC_W,
   parameter int unsigned MIDSCALE = ADC_MIDSCALE
) (
   input  logic [ADC_W-1:0] i_adc,
   output logic [ADC_W-1:0] o_mag_c
);

   localparam logic [ADC_W-1:0] MID = ADC_W'(MIDSCALE);

   // Fold the sample around midscale; full negative swing (0) maps to MIDSCALE.
   always_comb begin
      o_mag_c = '0;
      if (i_adc >= MID) begin
         o_mag_c = i_adc - MID;
      end else begin
         o_mag_c = MID - i_adc;
      end
   end

endmodule

// File: rtl/echo_detector.sv
// Post-ping echo detector: blanks ring-down, then looks for HOLD qualifying
// samples in a row and reports time-of-flight and peak, or a timeout.
module echo_detector
   import dvl_params::*;
#(
   parameter int unsigned ADC_W         = DEF_ADC_W,
   parameter int unsigned CNT_W         = DEF_CNT_W,
   parameter int unsigned BLANK_CYCLES  = DEF_BLANK_CYCLES,
   parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
   parameter int unsigned HOLD          = DEF_HOLD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [ADC_W-1:0] adc,
   input  logic             adc_valid,
   input  logic [ADC_W-1:0] threshold,
   output logic             rx_en,
   output logic             busy,
   output logic             echo_valid,
   output logic             timeout,
   output logic [CNT_W-1:0] tof,
   output logic [ADC_W-1:0] peak
);

   localparam int unsigned RUN_W = $clog2(HOLD + 1);

   rx_state_t          r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [ADC_W-1:0]   r_thr;
   logic [RUN_W-1:0]   r_run;
   logic [ADC_W-1:0]   r_peak_acc;
   logic [CNT_W-1:0]   r_cand;

   logic [ADC_W-1:0]   w_mag;
   logic               w_qual;
   logic               w_hit;
   logic               w_win_end;
   logic [RUN_W-1:0]   w_run_nxt;
   logic [ADC_W-1:0]   w_peak_nxt;
   logic [CNT_W-1:0]   w_cand_nxt;

   adc_magnitude #(
      .ADC_W    (ADC_W),
      .MIDSCALE (2 ** (ADC_W - 1))
   ) u_mag (
      .i_adc   (adc),
      .o_mag_c (w_mag)
   );

   // Run bookkeeping for the current sample: start a new candidate or extend it.
   always_comb begin
      w_qual     = adc_valid && (w_mag >= r_thr);
      w_run_nxt  = RUN_W'(1);
      w_peak_nxt = w_mag;
      w_cand_nxt = r_cnt;
      if (r_run != '0) begin
         w_run_nxt  = r_run + RUN_W'(1);
         w_peak_nxt = (w_mag > r_peak_acc) ? w_mag : r_peak_acc;
         w_cand_nxt = r_cand;
      end
      w_hit     = w_qual && (w_run_nxt == RUN_W'(HOLD));
      w_win_end = (r_cnt == CNT_W'(WINDOW_CYCLES - 1));
   end

   // Receive sequencer with result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_thr      <= '0;
         r_run      <= '0;
         r_peak_acc <= '0;
         r_cand     <= '0;
         tof        <= '0;
         peak       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state    <= BLANK;
                  r_cnt      <= '0;
                  r_thr      <= threshold;
                  r_run      <= '0;
                  r_peak_acc <= '0;
                  r_cand     <= '0;
               end
            end
            BLANK: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                  r_state <= LISTEN;
               end
            end
            LISTEN: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_qual) begin
                  r_run      <= w_run_nxt;
                  r_peak_acc <= w_peak_nxt;
                  r_cand     <= w_cand_nxt;
               end else if (adc_valid) begin
                  r_run      <= '0;
                  r_peak_acc <= '0;
               end
               // Detection takes priority over the window closing on the same cycle.
               if (w_hit) begin
                  r_state <= DONE_ECHO;
                  tof     <= w_cand_nxt;
                  peak    <= w_peak_nxt;
               end else if (w_win_end) begin
                  r_state <= DONE_TO;
                  tof     <= '0;
                  peak    <= '0;
               end
            end
            DONE_ECHO: r_state <= IDLE;
            DONE_TO:   r_state <= IDLE;
            default:   r_state <= IDLE;
         endcase
      end
   end

   assign rx_en      = (r_state == LISTEN);
   assign busy       = (r_state != IDLE);
   assign echo_valid = (r_state == DONE_ECHO);
   assign timeout    = (r_state == DONE_TO);

endmodule

// File: tb/tb_echo_detector.sv
// Scoreboard bench for echo_detector: a reference model predicts each
// transaction's outcome; a monitor checks pulses, results and status flags.
module tb_echo_detector;
   import dvl_params::*;

   localparam int unsigned ADC_W = DEF_ADC_W;
   localparam int unsigned CNT_W = DEF_CNT_W;
   localparam int          BLANK = int'(DEF_BLANK_CYCLES);
   localparam int          WIN   = int'(DEF_WINDOW_CYCLES);
   localparam int          HOLD  = int'(DEF_HOLD);
   localparam int          MID   = int'(ADC_MIDSCALE);

   logic             clk;
   logic             rst;
   logic             start;
   logic [ADC_W-1:0] adc;
   logic             adc_valid;
   logic [ADC_W-1:0] threshold;
   logic             rx_en;
   logic             busy;
   logic             echo_valid;
   logic             timeout;
   logic [CNT_W-1:0] tof;
   logic [ADC_W-1:0] peak;

   echo_detector dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .adc        (adc),
      .adc_valid  (adc_valid),
      .threshold  (threshold),
      .rx_en      (rx_en),
      .busy       (busy),
      .echo_valid (echo_valid),
      .timeout    (timeout),
      .tof        (tof),
      .peak       (peak)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit is_echo;
      int tof;
      int peak;
      int done_k;
   } exp_t;

   exp_t sb_q[$];
   int   samp[0:WIN];
   bit   val[0:WIN];
   int   checks = 0;
   int   failures = 0;
   int   tb_cnt = 0;
   int   tb_done_k = 0;
   bit   tb_active = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int mag_of(input int a);
      return (a >= MID) ? a - MID : MID - a;
   endfunction

   // First group of HOLD back-to-back valid listen-window samples that all clear the threshold.
   function automatic exp_t ref_model(input int thr);
      exp_t e;
      int   idx[$];
      for (int c = BLANK; c < WIN; c++) begin
         if (val[c]) idx.push_back(c);
      end
      for (int j = HOLD - 1; j < idx.size(); j++) begin
         bit ok = 1'b1;
         int pk = 0;
         for (int h = 0; h < HOLD; h++) begin
            int m = mag_of(samp[idx[j-h]]);
            if (m < thr) ok = 1'b0;
            if (m > pk) pk = m;
         end
         if (ok) begin
            e.is_echo = 1'b1;
            e.tof     = idx[j-HOLD+1];
            e.peak    = pk;
            e.done_k  = idx[j] + 1;
            return e;
         end
      end
      e.is_echo = 1'b0;
      e.tof     = 0;
      e.peak    = 0;
      e.done_k  = WIN;
      return e;
   endfunction

   // Monitor: status flags every cycle, result fields whenever a pulse appears.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         chk("busy", int'(busy), int'(tb_active));
         chk("rx_en", int'(rx_en), int'(tb_active && tb_cnt >= BLANK && tb_cnt < tb_done_k));
         chk("pulse", int'(echo_valid | timeout), int'(tb_active && tb_cnt == tb_done_k));
         if (echo_valid || timeout) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_pulse: echo=%0d timeout=%0d with empty scoreboard", echo_valid, timeout);
            end else begin
               e = sb_q.pop_front();
               chk("kind_echo", int'(echo_valid), int'(e.is_echo));
               chk("kind_timeout", int'(timeout), int'(!e.is_echo));
               chk("tof", int'(tof), e.tof);
               chk("peak", int'(peak), e.peak);
               chk("pulse_cycle", tb_cnt, e.done_k);
            end
         end
      end
   end

   // Drive one start..done transaction from samp/val; optional late start, reset abort, threshold churn.
   task automatic run_txn(input int thr_v, input int xstart_k, input int abort_k, input bit scramble);
      exp_t e;
      e = ref_model(thr_v);
      if (abort_k < 0) sb_q.push_back(e);
      @(posedge clk); #1;
      threshold = ADC_W'(thr_v);
      start     = 1'b1;
      adc_valid = 1'b0;
      @(posedge clk); #1;
      start     = 1'b0;
      tb_done_k = e.done_k;
      tb_cnt    = 0;
      tb_active = 1'b1;
      for (int k = 0; k <= e.done_k; k++) begin
         tb_cnt    = k;
         adc       = ADC_W'(samp[k]);
         adc_valid = val[k];
         start     = (k == xstart_k);
         if (scramble) threshold = ADC_W'($urandom_range(0, 1023));
         if (k == abort_k) begin
            rst       = 1'b0;
            tb_active = 1'b0;
            @(negedge clk);
            chk("abort_tof", int'(tof), 0);
            chk("abort_peak", int'(peak), 0);
            chk("abort_echo", int'(echo_valid), 0);
            chk("abort_timeout", int'(timeout), 0);
            @(posedge clk); #1;
            rst   = 1'b1;
            start = 1'b0;
            break;
         end
         @(posedge clk); #1;
      end
      start     = 1'b0;
      adc_valid = 1'b0;
      tb_active = 1'b0;
      tb_cnt    = 0;
      @(posedge clk); #1;
   endtask

   task automatic fill_base();
      for (int k = 0; k <= WIN; k++) begin
         samp[k] = MID;
         val[k]  = 1'b1;
      end
   endtask

   initial begin
      rst       = 1'b0;
      start     = 1'b0;
      adc       = ADC_W'(MID);
      adc_valid = 1'b0;
      threshold = '0;
      @(negedge clk);
      chk("reset_tof", int'(tof), 0);
      chk("reset_peak", int'(peak), 0);
      chk("reset_echo", int'(echo_valid), 0);
      chk("reset_timeout", int'(timeout), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Echo in window
      fill_base();
      samp[20] = 700; samp[21] = 750; samp[22] = 620;
      run_txn(100, -1, -1, 1'b0);
      chk("dir_echo_tof", int'(tof), 20);
      chk("dir_echo_peak", int'(peak), 238);

      // Strong ring-down inside blanking only
      fill_base();
      for (int k = 0; k < BLANK; k++) samp[k] = 1000;
      run_txn(100, -1, -1, 1'b0);
      chk("dir_blank_tof", int'(tof), 0);
      chk("dir_blank_peak", int'(peak), 0);

      // Broken run
      fill_base();
      samp[30] = 700; samp[31] = 700; samp[32] = 512;
      samp[33] = 700; samp[34] = 700; samp[35] = 700;
      run_txn(100, -1, -1, 1'b0);
      chk("dir_broken_tof", int'(tof), 33);
      chk("dir_broken_peak", int'(peak), 188);

      // Negative swing with a gap in valid samples
      fill_base();
      samp[40] = 300; val[41] = 1'b0; val[42] = 1'b0; samp[43] = 250; samp[44] = 280;
      run_txn(100, -1, -1, 1'b0);
      chk("dir_gap_tof", int'(tof), 40);
      chk("dir_gap_peak", int'(peak), 262);

      // Run completing on the last window cycle; stray start and threshold churn
      fill_base();
      samp[61] = 700; samp[62] = 700; samp[63] = 700;
      run_txn(100, 30, -1, 1'b1);
      chk("dir_edge_tof", int'(tof), 61);
      chk("dir_edge_peak", int'(peak), 188);

      // Reset mid-LISTEN with two qualifying samples banked, then a normal cycle
      fill_base();
      samp[20] = 700; samp[21] = 700;
      run_txn(100, -1, 22, 1'b0);
      fill_base();
      samp[20] = 700; samp[21] = 750; samp[22] = 620;
      run_txn(100, -1, -1, 1'b0);
      chk("dir_after_reset_tof", int'(tof), 20);
      chk("dir_after_reset_peak", int'(peak), 238);

      // Randomized transactions
      for (int t = 0; t < 40; t++) begin
         int thr;
         int xs;
         thr = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(40, 350));
         for (int k = 0; k <= WIN; k++) begin
            samp[k] = MID + int'($urandom_range(0, 80)) - 40;
            val[k]  = ($urandom_range(0, 99) < 85);
         end
         if ($urandom_range(0, 3) != 0) begin
            int b;
            int len;
            b   = int'($urandom_range(0, WIN - 1));
            len = int'($urandom_range(2, 5));
            for (int i = 0; i < len; i++) begin
               if (b + i <= WIN) begin
                  samp[b+i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(800, 1023))
                                                          : int'($urandom_range(0, 220));
               end
            end
         end
         xs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, WIN)) : -1;
         run_txn(thr, xs, -1, $urandom_range(0, 1) == 1);
      end

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
